// File: rtl/seg_to_hex_scan_if.sv
// Decoded-digit event port: valid/ready handshake carrying a digit index and nibble.
interface seg_to_hex_scan_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [2:0] ev_idx;
    logic [3:0] ev_nibble;

    modport master (
        output ev_valid,
        output ev_idx,
        output ev_nibble,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_idx,
        input  ev_nibble,
        output ev_ready
    );
endinterface

// File: rtl/seg_to_hex_scan.sv
// Scanned segment-bus monitor: debounces {segments, digit_sel}, decodes stable pairs back to
// hex nibbles, keeps a per-digit store and reports each accepted digit as an event.
module seg_to_hex_scan #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            segments,
    input  logic [DIGITS-1:0]     digit_sel,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     digit_valid,
    seg_to_hex_scan_if.master     ev,
    output logic                  overrun,
    output logic                  bad_code,
    output logic                  bad_sel
);

    localparam int unsigned SW = 8 + DIGITS;

    typedef enum logic [1:0] {StWait, StCount, StLocked} state_e;

    state_e               state_q, state_d;
    logic [SW-1:0]        sample_q;
    logic [7:0]           cnt_q, cnt_d;
    logic [4*DIGITS-1:0]  digits_q, digits_d;
    logic [DIGITS-1:0]    valid_q, valid_d;
    logic                 ev_valid_q, ev_valid_d;
    logic [2:0]           ev_idx_q, ev_idx_d;
    logic [3:0]           ev_nibble_q, ev_nibble_d;
    logic                 overrun_q, overrun_d;
    logic                 bad_code_q, bad_code_d;
    logic                 bad_sel_q, bad_sel_d;

    logic [7:0]           smp_seg;
    logic [DIGITS-1:0]    smp_sel;
    logic                 changed;
    logic                 accept;
    logic                 code_ok;
    logic [3:0]           nibble;
    logic                 sel_zero;
    logic                 sel_multi;
    logic [2:0]           sel_idx;
    logic                 good;
    logic                 hs;

    assign smp_seg   = sample_q[SW-1:DIGITS];
    assign smp_sel   = sample_q[DIGITS-1:0];
    assign changed   = ({segments, digit_sel} != sample_q);
    // The registered pair has been seen STABLE_CYCLES times by the time cnt_q shows it.
    assign accept    = (state_q == StCount) && (cnt_q == 8'(STABLE_CYCLES));
    assign sel_zero  = (smp_sel == '0);
    assign sel_multi = |(smp_sel & (smp_sel - DIGITS'(1)));
    assign good      = accept && !sel_zero && !sel_multi && code_ok;
    assign hs        = ev_valid_q && ev.ev_ready;

    // Exact-match decode of the sampled pattern and index of the selected digit.
    always_comb begin
        code_ok = 1'b1;
        nibble  = 4'h0;
        sel_idx = 3'd0;
        case (smp_seg)
            8'h80: nibble = 4'h0;
            8'h40: nibble = 4'h1;
            8'h20: nibble = 4'h2;
            8'h10: nibble = 4'h3;
            8'h08: nibble = 4'h4;
            8'h04: nibble = 4'h5;
            8'h02: nibble = 4'h6;
            8'h01: nibble = 4'h7;
            8'hC0: nibble = 4'h8;
            8'h60: nibble = 4'h9;
            8'h30: nibble = 4'hA;
            8'h18: nibble = 4'hB;
            8'h0C: nibble = 4'hC;
            8'h06: nibble = 4'hD;
            8'h03: nibble = 4'hE;
            8'hFF: nibble = 4'hF;
            default: code_ok = 1'b0;
        endcase
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (smp_sel[i]) sel_idx = 3'(i);
        end
    end

    // Stability counter and WAIT/COUNT/LOCKED sequencing.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (changed) begin
            cnt_d = 8'd1;
        end else if (cnt_q != 8'(STABLE_CYCLES)) begin
            cnt_d = cnt_q + 8'd1;
        end
        unique case (state_q)
            StWait:   if (changed) state_d = StCount;
            StCount:  if (changed) state_d = StCount;
                      else if (accept) state_d = StLocked;
            StLocked: if (changed) state_d = StCount;
            default:  state_d = StWait;
        endcase
    end

    // Accept action: store update, event load/replace, error pulses.
    always_comb begin
        digits_d    = digits_q;
        valid_d     = valid_q;
        ev_valid_d  = ev_valid_q;
        ev_idx_d    = ev_idx_q;
        ev_nibble_d = ev_nibble_q;
        overrun_d   = overrun_q;
        bad_sel_d   = accept && !sel_zero && sel_multi;
        bad_code_d  = accept && !sel_zero && !sel_multi && !code_ok;
        if (good) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                if (smp_sel[i]) begin
                    digits_d[4*i +: 4] = nibble;
                    valid_d[i]         = 1'b1;
                end
            end
            ev_valid_d  = 1'b1;
            ev_idx_d    = sel_idx;
            ev_nibble_d = nibble;
            // Replacing an event that is being consumed this edge is not an overrun.
            if (ev_valid_q && !ev.ev_ready) overrun_d = 1'b1;
        end else if (hs) begin
            ev_valid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StWait;
            sample_q    <= '0;
            cnt_q       <= '0;
            digits_q    <= '0;
            valid_q     <= '0;
            ev_valid_q  <= 1'b0;
            ev_idx_q    <= '0;
            ev_nibble_q <= '0;
            overrun_q   <= 1'b0;
            bad_code_q  <= 1'b0;
            bad_sel_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sample_q    <= {segments, digit_sel};
            cnt_q       <= cnt_d;
            digits_q    <= digits_d;
            valid_q     <= valid_d;
            ev_valid_q  <= ev_valid_d;
            ev_idx_q    <= ev_idx_d;
            ev_nibble_q <= ev_nibble_d;
            overrun_q   <= overrun_d;
            bad_code_q  <= bad_code_d;
            bad_sel_q   <= bad_sel_d;
        end
    end

    assign digits       = digits_q;
    assign digit_valid  = valid_q;
    assign ev.ev_valid  = ev_valid_q;
    assign ev.ev_idx    = ev_idx_q;
    assign ev.ev_nibble = ev_nibble_q;
    assign overrun      = overrun_q;
    assign bad_code     = bad_code_q;
    assign bad_sel      = bad_sel_q;

endmodule

// File: doc/seg_to_hex_scan.md
Name: seg_to_hex_scan

Overview:
Receive-side monitor for the scanned segment-display bus. It samples the 8-bit segment pattern and one-hot digit select, and waits until the pair has been stable for a programmable number of cycles. It then decodes the pattern back to a 4-bit hex nibble and stores it per digit. Each accepted digit is reported on a valid/ready event port, and invalid patterns or selects are flagged. It sits between the display driver and the self-check/readback logic.

Parameters:
DIGITS, 4, number of display digits (width of digit_sel), 1..8
STABLE_CYCLES, 3, consecutive identical samples required before a pair is accepted, 1..255

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
segments  in  8  segment pattern currently driven on the bus
digit_sel  in  DIGITS  one-hot digit enable; all-zero = blanking
digits  out  4*DIGITS  decoded nibble store; digit i at bits [4i+3:4i]
digit_valid  out  DIGITS  bit i set once digit i has been decoded since reset
ev_valid  out  1  decoded-digit event pending
ev_ready  in  1  consumer accepts event when ev_valid & ev_ready
ev_idx  out  3  digit index of pending event
ev_nibble  out  4  decoded value of pending event
overrun  out  1  sticky: event replaced before it was accepted
bad_code  out  1  one-cycle pulse: accepted pair had a pattern not in the code table
bad_sel  out  1  one-cycle pulse: accepted pair had multi-hot digit_sel

Behaviour:
- Reset (async, rst_n=0): digits=0, digit_valid=0, ev_valid=0, ev_idx=0, ev_nibble=0, overrun=0, bad_code=0, bad_sel=0, sample register=0, counter=0, FSM=WAIT.
- Code table, exact 8-bit matches only: 0=80 1=40 2=20 3=10 4=08 5=04 6=02 7=01 8=C0 9=60 A=30 B=18 C=0C D=06 E=03 F=FF (hex). Any other pattern is invalid.
- Sampling: {segments,digit_sel} is registered every cycle. If the new sample differs from the previous one, the counter loads 1 and the FSM goes to COUNT. If it is equal, the counter increments and saturates at STABLE_CYCLES.
- FSM states:
  - WAIT: after reset; leaves to COUNT on the first sample differing from the reset value.
  - COUNT: on the cycle the counter reaches STABLE_CYCLES, performs the accept action and moves to LOCKED.
  - LOCKED: holds until the sample changes, then returns to COUNT. Each stable pair is therefore accepted exactly once.
  - With STABLE_CYCLES=1, the accept action happens on the first sample after a change.
- Latency: a pair first present before edge k and held steady gives accept-action outputs visible after edge k+STABLE_CYCLES.
- Accept action, checked in priority order:
  - digit_sel==0: no action.
  - digit_sel multi-hot: pulse bad_sel; no store update.
  - Pattern invalid: pulse bad_code; no store update.
  - Otherwise: write the nibble to digits[i], set digit_valid[i], and load the event (ev_idx=i, ev_nibble=value, ev_valid=1).
- Event port:
  - ev_valid stays high until ev_valid & ev_ready.
  - ev_idx and ev_nibble are stable while ev_valid=1 and not accepted.
  - If a new event loads on the same edge as a handshake, the new event replaces the old one, ev_valid stays 1, and overrun is not set.
  - If a new event loads while the old one is unaccepted, the new event replaces it and overrun sets (sticky until reset).
- Pulses: bad_code and bad_sel are high for exactly one cycle per accepted offending pair.
- A change before the threshold restarts the count, so glitches shorter than STABLE_CYCLES produce no event.
- Asserting reset mid-count or with an event pending discards all state immediately.

Test Plan:
- STABLE_CYCLES=3, DIGITS=4: drive segments=C0, digit_sel=0100 from edge 10 → after edge 13, digits[11:8]=8, digit_valid=0100, ev_valid=1, ev_idx=2, ev_nibble=8; hold 20 cycles → no second event.
- Same digit, segments=30 held 2 cycles then 06 held 5 cycles → only one event, ev_nibble=D; no event for A.
- segments=55, digit_sel=0001 held → bad_code high exactly one cycle; digits and digit_valid unchanged. digit_sel=0011 with segments=80 → bad_sel pulse only.
- ev_ready=0; accept FF on digit 0, then 01 on digit 3 → ev_idx=3, ev_nibble=7, overrun=1. Raise ev_ready → ev_valid drops next edge.
- Sweep all 16 codes across digits 0..3 with ev_ready=1 → 16 events with correct nibbles; final digits matches the last value written per digit; overrun=0.
- Assert rst_n=0 mid-count with an event pending → all outputs 0 immediately; after release, the held pair is re-accepted after STABLE_CYCLES.
